// File: rtl/step_run_controller_if.sv
// CPU-side signals of the run/step controller: PC and fetch marker in,
// clock enable and status out.
`timescale 1ns/1ps
interface step_run_controller_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] i_pc;
    logic                  i_instrStart;
    logic                  o_cpuClkEn;
    logic                  o_halted;
    logic                  o_bpHit;
    logic [15:0]           o_cycleCount;

    modport master (
        output i_pc, i_instrStart,
        input  o_cpuClkEn, o_halted, o_bpHit, o_cycleCount
    );

    modport slave (
        input  i_pc, i_instrStart,
        output o_cpuClkEn, o_halted, o_bpHit, o_cycleCount
    );
endinterface

// File: rtl/step_run_controller.sv
// Run / single-cycle / single-instruction / breakpoint sequencer producing the CPU clock enable.
// Breakpoint compare and hit latch are built only when STEP_CTRL_BREAKPOINT_EN is defined.
`timescale 1ns/1ps
module step_run_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                  i_oszClk,
    input  logic                  i_reset,
    input  logic                  i_btnStep,
    input  logic                  i_swInstrNCycle,
    input  logic                  i_swStepNRun,
    input  logic                  i_swEnableBreakpoint,
    input  logic [ADDR_WIDTH-1:0] i_breakpointAddress,
    step_run_controller_if.slave  cpu_if
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HALT,
        S_STEP_CYCLE,
        S_STEP_INSTR,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      meta_q, sync_q;
    logic [1:0]      fill_q;
    logic [CW-1:0]   dbCnt_q, dbCnt_d;
    logic            dbLevel_q, dbLevel_d;
    logic            first_q, first_d;
    logic            bpHit_q, bpHit_d;
    logic            halted_q;
    logic [15:0]     cycleCnt_q;
    logic            stepReq, cpuClkEn, bpMatch;
    logic            btn_s, instrNCycle_s, stepNRun_s, bpEn_s, syncValid;

    assign btn_s         = sync_q[3];
    assign instrNCycle_s = sync_q[2];
    assign stepNRun_s    = sync_q[1];
    assign bpEn_s        = sync_q[0];
    // Synchronisers restart at 0 (= "run"); hold off run entry until real switch levels arrive.
    assign syncValid     = fill_q[1];

`ifdef STEP_CTRL_BREAKPOINT_EN
    assign bpMatch = bpEn_s & cpu_if.i_instrStart & (cpu_if.i_pc == i_breakpointAddress);
`else
    logic unused_bp;
    assign bpMatch   = 1'b0;
    assign unused_bp = ^{bpEn_s, i_breakpointAddress, cpu_if.i_pc};
`endif

    always_comb begin
        dbCnt_d   = dbCnt_q;
        dbLevel_d = dbLevel_q;
        if (btn_s == dbLevel_q) begin
            dbCnt_d = '0;
        end else if (dbCnt_q == DB_LAST) begin
            dbCnt_d   = '0;
            dbLevel_d = btn_s;
        end else begin
            dbCnt_d = dbCnt_q + CW'(1);
        end
    end

    assign stepReq = dbLevel_d & ~dbLevel_q;

    always_comb begin
        state_d  = state_q;
        first_d  = 1'b0;
        cpuClkEn = 1'b0;
        bpHit_d  = bpHit_q;
        case (state_q)
            S_HALT: begin
                if (stepReq) begin
                    if (instrNCycle_s) begin
                        state_d = S_STEP_INSTR;
                        first_d = 1'b1;
                    end else begin
                        state_d = S_STEP_CYCLE;
                    end
                end else if (syncValid && !stepNRun_s && !bpHit_q) begin
                    state_d = S_RUN;
                end
            end
            S_STEP_CYCLE: begin
                cpuClkEn = 1'b1;
                state_d  = S_HALT;
            end
            S_STEP_INSTR: begin
                if (first_q) begin
                    cpuClkEn = 1'b1;
                end else if (cpu_if.i_instrStart) begin
                    state_d = S_HALT;
                end else begin
                    cpuClkEn = 1'b1;
                end
            end
            S_RUN: begin
                if (bpMatch) begin
                    state_d = S_HALT;
                end else begin
                    cpuClkEn = 1'b1;
                    if (stepNRun_s) state_d = S_HALT;
                end
            end
            default: state_d = S_HALT;
        endcase
        if (stepReq || stepNRun_s) bpHit_d = 1'b0;
        if (state_q == S_RUN && bpMatch) bpHit_d = 1'b1;
    end

    always_ff @(posedge i_oszClk or posedge i_reset) begin
        if (i_reset) begin
            meta_q     <= '0;
            sync_q     <= '0;
            fill_q     <= '0;
            dbCnt_q    <= '0;
            dbLevel_q  <= 1'b0;
            state_q    <= S_HALT;
            first_q    <= 1'b0;
            bpHit_q    <= 1'b0;
            halted_q   <= 1'b1;
            cycleCnt_q <= '0;
        end else begin
            meta_q     <= {i_btnStep, i_swInstrNCycle, i_swStepNRun, i_swEnableBreakpoint};
            sync_q     <= meta_q;
            fill_q     <= {fill_q[0], 1'b1};
            dbCnt_q    <= dbCnt_d;
            dbLevel_q  <= dbLevel_d;
            state_q    <= state_d;
            first_q    <= first_d;
            bpHit_q    <= bpHit_d;
            halted_q   <= (state_d == S_HALT);
            cycleCnt_q <= cycleCnt_q + {15'd0, cpuClkEn};
        end
    end

    assign cpu_if.o_cpuClkEn   = cpuClkEn;
    assign cpu_if.o_halted     = halted_q;
    assign cpu_if.o_bpHit      = bpHit_q;
    assign cpu_if.o_cycleCount = cycleCnt_q;
endmodule

// File: tb/tb_step_run_controller.sv
// Testbench for step_run_controller: a tiny CPU model (N micro-steps per instruction)
// follows the clock enable while scenario tasks check enable counts against stepping rules.
`timescale 1ns/1ps
module tb_step_run_controller;
    localparam int D  = 4;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn, swI, swS, swB;
    logic [AW-1:0] bpAddr;

    step_run_controller_if #(.ADDR_WIDTH(AW)) cpu_if ();

    step_run_controller #(.DEBOUNCE_CYCLES(D), .ADDR_WIDTH(AW)) dut (
        .i_oszClk             (clk),
        .i_reset              (rst),
        .i_btnStep            (btn),
        .i_swInstrNCycle      (swI),
        .i_swStepNRun         (swS),
        .i_swEnableBreakpoint (swB),
        .i_breakpointAddress  (bpAddr),
        .cpu_if               (cpu_if)
    );

    always #100 clk = ~clk;

    int unsigned   nStep;
    int unsigned   ustep;
    logic [AW-1:0] pc;
    int            en_count;
    logic          en_s, start_s;
    logic [AW-1:0] pc_s;
    int            exp_total;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic drive_cpu();
        cpu_if.i_pc         = pc;
        cpu_if.i_instrStart = (ustep == 0);
    endtask

    // One clock: sample at the falling edge, advance the CPU model after the rising edge.
    task automatic tick();
        @(negedge clk);
        en_s    = cpu_if.o_cpuClkEn;
        start_s = cpu_if.i_instrStart;
        pc_s    = cpu_if.i_pc;
        @(posedge clk);
        #1;
        if (en_s === 1'b1) begin
            en_count++;
            if (ustep == nStep - 1) begin
                ustep = 0;
                pc    = pc + 1'b1;
            end else begin
                ustep = ustep + 1;
            end
        end
        drive_cpu();
    endtask

    task automatic press(input int bounces, output int lat);
        int base;
        for (int b = 0; b < bounces; b++) begin
            btn = 1'b1;
            repeat ($urandom_range(1, D - 1)) tick();
            btn = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        btn  = 1'b1;
        lat  = 0;
        base = en_count;
        while (en_count == base && lat < 40) begin
            tick();
            lat++;
        end
        repeat ($urandom_range(0, 8)) tick();
        btn = 1'b0;
        repeat (30) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 1'b0; swI = 1'b0; swS = 1'b1; swB = 1'b0; bpAddr = '0;
        nStep = 4; ustep = 0; pc = '0; en_count = 0; exp_total = 0;
        drive_cpu();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (cpu_if.o_cpuClkEn !== 1'b0 || cpu_if.o_halted !== 1'b1 || cpu_if.o_bpHit !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: en=%b halted=%b bpHit=%b, expected 0 1 0",
                     cpu_if.o_cpuClkEn, cpu_if.o_halted, cpu_if.o_bpHit);
        end
        rst = 1'b0;
        repeat (20) tick();
        n_cmp++;
        if (en_count !== 0) begin
            n_err++;
            $display("FAIL reset_idle_enables: got %0d expected 0", en_count);
        end
        n_cmp++;
        if (cpu_if.o_halted !== 1'b1 || cpu_if.o_cycleCount !== 16'd0) begin
            n_err++;
            $display("FAIL reset_idle_state: halted=%b count=%0d expected 1 0",
                     cpu_if.o_halted, cpu_if.o_cycleCount);
        end
    endtask

    task automatic test_step_cycle();
        int lat, base;
        swI = 1'b0; swS = 1'b1;
        repeat (3) tick();
        for (int it = 0; it < 3; it++) begin
            base = en_count;
            press($urandom_range(1, 3), lat);
            exp_total += 1;
            n_cmp++;
            if (lat !== D + 3) begin
                n_err++;
                $display("FAIL cycle_press_latency: got %0d expected %0d", lat, D + 3);
            end
            n_cmp++;
            if (en_count - base !== 1) begin
                n_err++;
                $display("FAIL cycle_enables: got %0d expected 1", en_count - base);
            end
            n_cmp++;
            if (cpu_if.o_cycleCount !== 16'(exp_total) || cpu_if.o_halted !== 1'b1) begin
                n_err++;
                $display("FAIL cycle_count: count=%0d halted=%b expected %0d 1",
                         cpu_if.o_cycleCount, cpu_if.o_halted, exp_total);
            end
        end
    endtask

    task automatic test_step_instr();
        int lat, base, expn;
        swI = 1'b1; swS = 1'b1;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                nStep = 4; ustep = 0;
            end else begin
                nStep = $urandom_range(2, 6);
                ustep = $urandom_range(0, nStep - 1);
            end
            drive_cpu();
            repeat (3) tick();
            expn = (ustep == 0) ? nStep : nStep - ustep;
            base = en_count;
            press($urandom_range(0, 2), lat);
            exp_total += expn;
            n_cmp++;
            if (lat !== D + 3) begin
                n_err++;
                $display("FAIL instr_press_latency: got %0d expected %0d", lat, D + 3);
            end
            n_cmp++;
            if (en_count - base !== expn) begin
                n_err++;
                $display("FAIL instr_enables: got %0d expected %0d (N=%0d)", en_count - base, expn, nStep);
            end
            n_cmp++;
            if (cpu_if.o_cycleCount !== 16'(exp_total) || cpu_if.o_halted !== 1'b1) begin
                n_err++;
                $display("FAIL instr_count: count=%0d halted=%b expected %0d 1",
                         cpu_if.o_cycleCount, cpu_if.o_halted, exp_total);
            end
        end
    endtask

    task automatic test_run();
        int len, base;
        swB = 1'b0; swS = 1'b1;
        for (int it = 0; it < 3; it++) begin
            len  = $urandom_range(1, 30);
            base = en_count;
            swS  = 1'b0;
            repeat (len) tick();
            swS  = 1'b1;
            repeat (6) tick();
            exp_total += len;
            n_cmp++;
            if (en_count - base !== len) begin
                n_err++;
                $display("FAIL run_enables: got %0d expected %0d", en_count - base, len);
            end
            n_cmp++;
            if (cpu_if.o_cycleCount !== 16'(exp_total) || cpu_if.o_halted !== 1'b1) begin
                n_err++;
                $display("FAIL run_count: count=%0d halted=%b expected %0d 1",
                         cpu_if.o_cycleCount, cpu_if.o_halted, exp_total);
            end
        end
    endtask

`ifdef STEP_CTRL_BREAKPOINT_EN
    task automatic test_breakpoint();
        int  base, lat;
        logic found;
        nStep = $urandom_range(2, 5); ustep = 0; pc = 16'h0010;
        drive_cpu();
        bpAddr = 16'h0012; swB = 1'b1; swI = 1'b1; swS = 1'b1;
        repeat (3) tick();
        base  = en_count;
        found = 1'b0;
        swS   = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (pc_s == 16'h0012 && start_s === 1'b1) begin
                found = 1'b1;
                n_cmp++;
                if (en_s !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_fetch_blocked: en=%b expected 0", en_s);
                end
            end
        end
        n_cmp++;
        if (found !== 1'b1 || en_count - base !== 2 * nStep) begin
            n_err++;
            $display("FAIL bp_run_enables: reached=%b enables=%0d expected 1 %0d",
                     found, en_count - base, 2 * nStep);
        end
        n_cmp++;
        if (cpu_if.o_bpHit !== 1'b1 || cpu_if.o_halted !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hit_latch: bpHit=%b halted=%b expected 1 1", cpu_if.o_bpHit, cpu_if.o_halted);
        end
        base = en_count;
        repeat (10) tick();
        n_cmp++;
        if (en_count !== base || cpu_if.o_halted !== 1'b1 || cpu_if.o_bpHit !== 1'b1) begin
            n_err++;
            $display("FAIL bp_stays_halted: enables=%0d halted=%b bpHit=%b expected 0 1 1",
                     en_count - base, cpu_if.o_halted, cpu_if.o_bpHit);
        end
        press($urandom_range(0, 2), lat);
        n_cmp++;
        if (lat !== D + 3) begin
            n_err++;
            $display("FAIL bp_step_latency: got %0d expected %0d", lat, D + 3);
        end
        n_cmp++;
        if (cpu_if.o_bpHit !== 1'b0 || pc <= 16'h0013) begin
            n_err++;
            $display("FAIL bp_resume: bpHit=%b pc=%h expected 0 and pc past 0013", cpu_if.o_bpHit, pc);
        end
        swS = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (cpu_if.o_halted !== 1'b1) begin
            n_err++;
            $display("FAIL bp_stop: halted=%b expected 1", cpu_if.o_halted);
        end
        swB = 1'b0;
    endtask
`else
    task automatic test_breakpoint();
        int base, len;
        nStep = $urandom_range(2, 5); ustep = 0; pc = 16'h0010;
        drive_cpu();
        bpAddr = 16'h0012; swB = 1'b1; swS = 1'b1;
        repeat (3) tick();
        len  = 4 * nStep + $urandom_range(0, 5);
        base = en_count;
        swS  = 1'b0;
        repeat (len) tick();
        swS  = 1'b1;
        repeat (6) tick();
        exp_total += len;
        n_cmp++;
        if (en_count - base !== len || pc <= 16'h0012) begin
            n_err++;
            $display("FAIL nobp_run_enables: got %0d pc=%h expected %0d and pc past 0012",
                     en_count - base, pc, len);
        end
        n_cmp++;
        if (cpu_if.o_bpHit !== 1'b0 || cpu_if.o_cycleCount !== 16'(exp_total)) begin
            n_err++;
            $display("FAIL nobp_latch: bpHit=%b count=%0d expected 0 %0d",
                     cpu_if.o_bpHit, cpu_if.o_cycleCount, exp_total);
        end
        swB = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_step();
        int lat, base;
        swI = 1'b1; swS = 1'b1; swB = 1'b0;
        nStep = 6; ustep = 0;
        drive_cpu();
        repeat (3) tick();
        base = en_count;
        btn  = 1'b1;
        lat  = 0;
        while (en_count == base && lat < 40) begin
            tick();
            lat++;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (lat >= 40 || cpu_if.o_cpuClkEn !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_step_en: en=%b lat=%0d expected 0 with step started",
                     cpu_if.o_cpuClkEn, lat);
        end
        btn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_total = 0;
        n_cmp++;
        if (cpu_if.o_halted !== 1'b1 || cpu_if.o_cycleCount !== 16'd0 || cpu_if.o_bpHit !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_step_state: halted=%b count=%0d bpHit=%b expected 1 0 0",
                     cpu_if.o_halted, cpu_if.o_cycleCount, cpu_if.o_bpHit);
        end
        base = en_count;
        repeat (20) tick();
        n_cmp++;
        if (en_count - base !== 0 || cpu_if.o_cycleCount !== 16'(exp_total)) begin
            n_err++;
            $display("FAIL reset_no_pending_step: enables=%0d count=%0d expected 0 0",
                     en_count - base, cpu_if.o_cycleCount);
        end
    endtask

    initial begin
        test_reset();
        test_step_cycle();
        test_step_instr();
        test_run();
        test_breakpoint();
        test_reset_mid_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/step_run_controller.md
# step_run_controller

Run/step/breakpoint sequencer for the CPU clock on the 5 MHz design clock. It takes the front-panel step button and mode switches, debounces and synchronises them, and drives a per-cycle clock enable for the CPU core. It supports free running, single micro-cycle stepping, single-instruction stepping, and halting on a program-counter breakpoint. It sits between the board-level controls and the generated CPU, next to the breakpoint latch.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 50000: consecutive stable samples needed to accept a new step-button level (10 ms at 5 MHz).
- ADDR_WIDTH, default 16: width of the PC and the breakpoint address.

Ports:
- i_oszClk, input, 1: design clock; all state updates on its rising edge.
- i_reset, input, 1: reset, asynchronous and active-high.
- i_btnStep, input, 1: raw step button, 1 = pressed; asynchronous.
- i_swInstrNCycle, input, 1: 1 = step whole instruction, 0 = step one cycle; asynchronous.
- i_swStepNRun, input, 1: 1 = step mode, 0 = run mode; asynchronous.
- i_swEnableBreakpoint, input, 1: 1 = breakpoint compare active; asynchronous.
- i_breakpointAddress, input, ADDR_WIDTH: breakpoint PC; quasi-static.
- i_pc, input, ADDR_WIDTH: current CPU program counter.
- i_instrStart, input, 1: CPU is in micro-step 0 (fetch) of an instruction.
- o_cpuClkEn, output, 1: CPU advances on this edge when 1; combinational (Mealy) output.
- o_halted, output, 1: registered; 1 when state is HALT.
- o_bpHit, output, 1: registered; breakpoint-hit latch.
- o_cycleCount, output, 16: count of enabled cycles; wraps 0xFFFF→0x0000.

## Operation
- Synchronisers: the three switches and i_btnStep each pass through a 2-flop synchroniser. Every "switch" reference below means the synchronised value.
- Debounce: a counter restarts whenever the synchronised button differs from the debounced level. The debounced level updates once the counter reaches DEBOUNCE_CYCLES−1. A 0→1 transition of the debounced level produces a one-cycle stepReq.
- bpMatch = breakpoint enabled ∧ i_instrStart ∧ (i_pc == i_breakpointAddress).
- States:
  - HALT: enable = 0.
    - stepReq with InstrNCycle = 0 → STEP_CYCLE.
    - stepReq with InstrNCycle = 1 → STEP_INSTR.
    - Otherwise, StepNRun = 0 ∧ ¬o_bpHit → RUN.
    - stepReq takes priority over run entry.
  - STEP_CYCLE: enable = 1 for exactly one cycle → HALT.
  - STEP_INSTR: enable = 1 in the first cycle unconditionally. In later cycles, enable = ¬i_instrStart. When i_instrStart = 1 in a non-first cycle, go to HALT with enable = 0, so the CPU stops at the fetch of the next instruction.
  - RUN: enable = ¬bpMatch.
    - bpMatch → HALT and set o_bpHit; the breakpoint instruction is not fetched.
    - StepNRun = 1 → HALT; enable is still 1 in that cycle.
- o_bpHit clears on any stepReq or when StepNRun = 1. Run then resumes only after a step past the breakpoint, or after a step/run switch toggle.
- o_cycleCount increments on every edge where o_cpuClkEn = 1.

## Timing
- Reset values: state HALT, o_cpuClkEn 0, o_halted 1, o_bpHit 0, o_cycleCount 0, debounce counter 0, debounced level 0, synchronisers 0.
- Button latency: press to stepReq is 2 (sync) + DEBOUNCE_CYCLES cycles. The first enabled cycle follows on the next edge.
- Switch latency: 2 cycles of synchronisation, then one state transition.
- A held button produces exactly one stepReq. Bounces shorter than DEBOUNCE_CYCLES produce none.
- stepReq arriving while in STEP_CYCLE, STEP_INSTR or RUN is dropped.
- Reset asserted mid-step: enable drops immediately (asynchronous). The state machine returns to HALT with no pending step.
- A breakpoint at the instruction where STEP_INSTR starts is ignored, because breakpoints are only checked in RUN.

## Configuration
- STEP_CTRL_BREAKPOINT_EN defined: breakpoint compare and the o_bpHit latch are implemented as above.
- STEP_CTRL_BREAKPOINT_EN undefined:
  - bpMatch is constant 0 and o_bpHit is tied to 0.
  - i_swEnableBreakpoint and i_breakpointAddress are unused.
  - RUN leaves only via StepNRun = 1.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset, then hold StepNRun = 1 for 20 cycles → o_cpuClkEn stays 0, o_halted = 1, o_cycleCount = 0.
- InstrNCycle = 0; press the step button for 10 cycles with 2-cycle bounces at the start → exactly one enabled cycle, o_cycleCount = 1, back in HALT.
- InstrNCycle = 1; i_instrStart pulses every 4 cycles; press step → exactly 4 enabled cycles; enable is 0 in the cycle i_instrStart = 1; o_cycleCount = 4.
- Run with breakpoint 0x0012 enabled; drive i_pc = 0x0012 with i_instrStart = 1 → enable 0 in that cycle; next cycle o_bpHit = 1 and o_halted = 1; stays halted while StepNRun = 0.
- From the breakpoint halt, press step (InstrNCycle = 1) → o_bpHit clears, one instruction executes, then RUN resumes.
- Assert i_reset during STEP_INSTR → o_cpuClkEn is 0 immediately; after release, HALT with o_cycleCount = 0.
